// File: rtl/pci_pkg.sv
// Shared PCI target definitions: bus command codes, burst mode codes and
// the burst address generator state encoding.
package pci_pkg;

    localparam logic [3:0] READ_CMD      = 4'b0110;
    localparam logic [3:0] WRITE_CMD     = 4'b0111;
    localparam logic [3:0] READ_MUL_CMD  = 4'b1100;
    localparam logic [3:0] READ_LINE_CMD = 4'b1110;

    localparam logic [1:0] INCREMENT = 2'b00;
    localparam logic [1:0] RESERVED1 = 2'b01;
    localparam logic [1:0] WRAP      = 2'b10;
    localparam logic [1:0] RESERVED2 = 2'b11;

    typedef enum logic [1:0] {
        AG_IDLE,
        AG_LOAD,
        AG_ACTIVE,
        AG_DISCONNECT
    } addr_gen_state_t;

endpackage

// File: rtl/pci_addr_step.sv
// Next dword pointer for one burst advance, plus a flag for advances that end the burst.
// Cache-line wrap is only built when PCI_ADDR_GEN_WRAP_EN is defined.
module pci_addr_step
    import pci_pkg::*;
#(
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic [ADDR_W-1:0] ptr,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] next_ptr,
    output logic              leave
);

`ifdef PCI_ADDR_GEN_WRAP_EN
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS - 1);
`else
    localparam logic [ADDR_W-1:0] unused_line_mask = ADDR_W'(LINE_WORDS - 1);
`endif

    always_comb begin
        next_ptr = ptr;
        leave    = 1'b0;
        case (mode)
            INCREMENT: begin
                next_ptr = ptr + ADDR_W'(1);
                leave    = &ptr;
            end
`ifdef PCI_ADDR_GEN_WRAP_EN
            // Low line bits roll over, upper bits stay put: never leaves the window.
            WRAP: next_ptr = (ptr & ~LINE_MASK) | ((ptr + ADDR_W'(1)) & LINE_MASK);
`endif
            default: leave = 1'b1;
        endcase
    end

endmodule

// File: rtl/pci_addr_gen.sv
// PCI target burst address generator: dword index per data phase plus the Done
// continue/disconnect flag. Optional cache-line wrap via PCI_ADDR_GEN_WRAP_EN.
module pci_addr_gen
    import pci_pkg::*;
#(
    parameter int unsigned ADDR_W     = 6,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ADDRESS_FF,
    input  logic [1:0]        mode,
    input  logic [3:0]        CMD,
    input  logic              rst_gen,
    input  logic              update_add_gen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              Done,
    output logic [15:0]       beat_cnt
);

    localparam int unsigned LC_W = $clog2(LINE_WORDS) + 1;

    addr_gen_state_t   state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [LC_W-1:0]   line_cnt, line_nxt;
    logic [15:0]       beat_nxt, beat_inc;

    logic [ADDR_W-1:0] start;
    logic              in_win;
    logic [ADDR_W-1:0] step_src, step_ptr;
    logic              step_leave;
    logic              line_last, stop, adv;
    logic [1:0]        unused_byte_lane;

    assign unused_byte_lane = ADDRESS_FF[1:0];
    assign start  = ADDRESS_FF[ADDR_W+1:2];
    assign in_win = (ADDRESS_FF[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign adv    = ~update_add_gen;

    // In LOAD the first step is taken from the live start address, not ptr.
    assign step_src = (state == AG_LOAD) ? start : ptr;

    pci_addr_step #(
        .ADDR_W     (ADDR_W),
        .LINE_WORDS (LINE_WORDS)
    ) u_step (
        .ptr      (step_src),
        .mode     (mode),
        .next_ptr (step_ptr),
        .leave    (step_leave)
    );

    assign line_last = (CMD == READ_LINE_CMD) && ((line_cnt + LC_W'(1)) == LC_W'(LINE_WORDS));
    assign stop      = step_leave || line_last;
    assign beat_inc  = (beat_cnt == 16'hFFFF) ? beat_cnt : beat_cnt + 16'd1;

    // Next-state and combinational phase outputs; a disconnecting advance leaves ptr on the last phase.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        line_nxt  = line_cnt;
        beat_nxt  = beat_cnt;
        mem_addr  = ptr;
        Done      = 1'b1;

        case (state)
            AG_IDLE: begin
                if (rst_gen) state_nxt = AG_LOAD;
            end
            AG_LOAD: begin
                mem_addr = start;
                Done     = in_win;
                ptr_nxt  = start;
                if (!in_win) begin
                    state_nxt = AG_DISCONNECT;
                end else if (adv) begin
                    beat_nxt  = beat_inc;
                    line_nxt  = line_cnt + LC_W'(1);
                    if (stop) begin
                        state_nxt = AG_DISCONNECT;
                    end else begin
                        state_nxt = AG_ACTIVE;
                        ptr_nxt   = step_ptr;
                    end
                end else begin
                    state_nxt = AG_ACTIVE;
                end
            end
            AG_ACTIVE: begin
                if (adv) begin
                    beat_nxt = beat_inc;
                    line_nxt = line_cnt + LC_W'(1);
                    if (stop) state_nxt = AG_DISCONNECT;
                    else      ptr_nxt   = step_ptr;
                end
            end
            AG_DISCONNECT: begin
                Done = 1'b0;
            end
            default: begin
                state_nxt = AG_IDLE;
            end
        endcase

        if (!rst_gen) begin
            state_nxt = AG_IDLE;
            beat_nxt  = 16'd0;
            line_nxt  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= AG_IDLE;
            ptr      <= '0;
            line_cnt <= '0;
            beat_cnt <= 16'd0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            line_cnt <= line_nxt;
            beat_cnt <= beat_nxt;
        end
    end

endmodule

// File: doc/pci_addr_gen.md
# pci_addr_gen

Burst address generator for the PCI target data path, directly downstream of the PCI target control FSM. It consumes the latched start address, burst mode and command, plus the control FSM's active-low load and advance strobes. It produces the dword index into the target's local memory for every data phase. It also drives `Done`, which tells the control FSM whether the current phase can complete; `Done` low makes the FSM signal `Stop` and disconnect.

## Interface
Parameters:
- `ADDR_W`, 6: memory index width. The target window holds 2^ADDR_W dwords.
- `BASE_ADDR`, 32'h0000_1000: window base. Bits [31:ADDR_W+2] are decoded.
- `LINE_WORDS`, 4: cache-line length in dwords. Must be a power of two and no larger than 2^ADDR_W.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `ADDRESS_FF`  in  32: latched byte start address. Valid from the first cycle after `rst_gen` rises.
- `mode`  in  2: burst ordering (00 linear, 10 cache-line wrap, 01/11 reserved).
- `CMD`  in  4: latched bus command (0110 read, 0111 write, 1100 read multiple, 1110 read line).
- `rst_gen`  in  1: active-low synchronous restart. Held low while the control FSM is idle.
- `update_add_gen`  in  1: active-low advance strobe. One strobe per completed data phase.
- `mem_addr`  out  ADDR_W: dword index for the current data phase.
- `Done`  out  1: high when the current phase address is valid and the burst may continue.
- `beat_cnt`  out  16: number of completed data phases in this burst. Saturates at 16'hFFFF.

## Operation
- States: IDLE, LOAD, ACTIVE, DISCONNECT. The state register and the pointer `ptr` (ADDR_W bits) are reset asynchronously.
- `rst_gen`=0 forces IDLE, `beat_cnt`=0 and `line_cnt`=0 on the next edge from any state. It overrides `update_add_gen`.
- IDLE → LOAD on the first edge at which `rst_gen`=1.
- LOAD:
  - `mem_addr` = ADDRESS_FF[ADDR_W+1:2], taken combinationally.
  - `Done` = in_window(ADDRESS_FF).
  - If `Done`=0, go to DISCONNECT.
  - Otherwise `ptr` loads start+step if `update_add_gen`=0, else `ptr` loads start. Then go to ACTIVE, or to DISCONNECT under the rules below.
- ACTIVE: `mem_addr`=`ptr`, `Done`=1. Each `update_add_gen`=0 advances `ptr` by one step and increments `beat_cnt`.
- Step rules:
  - Linear (00): `ptr`+1. Advancing from all-ones leaves the window, so go to DISCONNECT.
  - Wrap (10): the low log2(LINE_WORDS) bits increment modulo LINE_WORDS and the upper bits are held. The burst never leaves the window.
  - Reserved (01/11): the first advance goes to DISCONNECT.
- Read line (1110): `line_cnt` counts advances. The advance that brings it to LINE_WORDS goes to DISCONNECT. Other commands have no length limit.
- DISCONNECT: `mem_addr` holds its last value and `Done`=0. Leaves only on `rst_gen`=0.
- in_window(a) = (a[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]).

## Timing
- Reset values:
  - state IDLE, `ptr`=0, `beat_cnt`=0, `line_cnt`=0.
  - `mem_addr`=0 and `Done`=1. Done is high in IDLE so it never causes a spurious stop.
- `mem_addr` and `Done` are combinational from state, `ptr` and (in LOAD) `ADDRESS_FF`. They are valid in the same cycle as the data phase. Zero latency from LOAD to the first address.
- An advance strobed in cycle n gives the new `mem_addr`/`Done` in cycle n+1.
- `Done` falls in the cycle after the last legal advance. The phase that was strobed has already completed.
- An async `rst` mid-burst returns to IDLE immediately, with outputs at their reset values.
- `update_add_gen` held low continuously advances once per cycle.

## Configuration
- `PCI_ADDR_GEN_WRAP_EN`:
  - Defined: mode 10 performs cache-line wrap as specified.
  - Undefined: mode 10 is treated as reserved and disconnects after the first advance. The wrap step logic is not synthesized.

## Structure
- Shared package `pci_pkg`:
  - command encodings (READ_CMD, WRITE_CMD, READ_MUL_CMD, READ_LINE_CMD);
  - mode encodings (INCREMENT, WRAP, RESERVED1, RESERVED2);
  - the address-generator state enum.
- One natural sub-module, `pci_addr_step`: combinational next pointer plus a window-exit flag. Inputs are `ptr`, `mode` and LINE_WORDS.

## Test plan
Parameters for all scenarios: ADDR_W=6, BASE_ADDR=32'h1000, LINE_WORDS=4.
- Linear write: ADDRESS_FF=32'h1008, CMD=0111, 4 advances → `mem_addr` 2,3,4,5,6; `Done`=1 throughout; `beat_cnt`=4.
- Wrap: ADDRESS_FF=32'h100E (word 3, mode 10), 4 advances → `mem_addr` 3,0,1,2,3; `Done`=1. With the macro undefined → 3, then `Done`=0.
- Window end: ADDRESS_FF=32'h10F8, linear, 2 advances → `mem_addr` 62,63; `Done`=0 after the second advance and held until `rst_gen`=0.
- Read line: ADDRESS_FF=32'h1010, CMD=1110 → `mem_addr` 4,5,6,7; `Done`=0 after the 4th advance.
- Reserved / out of window:
  - ADDRESS_FF=32'h1001 → `Done`=1 in LOAD, 0 after the 1st advance.
  - ADDRESS_FF=32'h2000 → `Done`=0 in LOAD.
- Reset: assert `rst` in mid-burst at `mem_addr`=5 → same cycle `mem_addr`=0, `Done`=1, `beat_cnt`=0. A `rst_gen`=0 pulse during ACTIVE restarts at the new ADDRESS_FF.
